mips_main_control: RTL and testbench

Multicycle main control FSM for the MIPS processor. Sequences each instruction through fetch, decode, execute, memory and writeback steps from the 6-bit opcode. Drives every datapath enable and mux select. Produces the 3-bit `aluop` consumed by `alu_control`, which combines it with `funct` into `alucontrol`. Memory accesses stall on a `mem_ready` handshake.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/mips_main_control.sv | 158 +++++++++++++++
 tb/tb_mips_main_control.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALU op codes,
// main-control states and datapath select encodings.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Must stay in step with the alu_control decoder.
    typedef enum logic [2:0] {
        AluAdd   = 3'b000,
        AluSub   = 3'b001,
        AluFunct = 3'b010,
        AluAnd   = 3'b011,
        AluOr    = 3'b100,
        AluSlt   = 3'b101
    } aluop_t;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StAluWb   = 4'd7,
        StImmEx   = 4'd8,
        StImmWb   = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// from the opcode and drives all datapath enables and selects.
module mips_main_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       branch_ne,
    output logic       irwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       imm_zext,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       illegal_op
);

    state_t state_q, state_d;
    aluop_t aluop_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        imm_zext   = 1'b0;
        pcsrc      = PCSRC_ALU;
        aluop_int  = AluAdd;
        illegal_op = 1'b0;

        case (state_q)
            StFetch: begin
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                alusrcb = SRCB_BRIMM;
                case (op)
                    OP_LW, OP_SW:                      state_d = StMemAdr;
                    OP_RTYPE:                          state_d = StRtypeEx;
                    OP_BEQ, OP_BNE:                    state_d = StBranch;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = StImmEx;
                    OP_J:                              state_d = StJump;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StRtypeEx: begin
                alusrca   = 1'b1;
                alusrcb   = SRCB_REG;
                aluop_int = AluFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StImmEx: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                case (op)
                    OP_ANDI: begin
                        aluop_int = AluAnd;
                        imm_zext  = 1'b1;
                    end
                    OP_ORI: begin
                        aluop_int = AluOr;
                        imm_zext  = 1'b1;
                    end
                    OP_SLTI: aluop_int = AluSlt;
                    default: aluop_int = AluAdd;
                endcase
                state_d = StImmWb;
            end
            StImmWb: begin
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                alusrca   = 1'b1;
                alusrcb   = SRCB_REG;
                aluop_int = AluSub;
                pcsrc     = PCSRC_ALUOUT;
                branch    = (op == OP_BEQ);
                branch_ne = (op == OP_BNE);
                state_d   = StFetch;
            end
            StJump: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;  // unused encoding: recover with all enables low
        endcase

        // Reset must suppress the FETCH enables, which otherwise follow mem_ready.
        if (!rst_n) begin
            pcwrite   = 1'b0;
            branch    = 1'b0;
            branch_ne = 1'b0;
            irwrite   = 1'b0;
            memwrite  = 1'b0;
            regwrite  = 1'b0;
        end
    end

    assign aluop = aluop_int;

endmodule

// File: tb/tb_mips_main_control.sv
// Scoreboard bench for mips_main_control: expected output vectors are queued as
// each cycle's stimulus is driven and compared mid-cycle by a monitor.
module tb_mips_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite, branch, branch_ne, irwrite, memwrite, iord;
    logic       regwrite, regdst, memtoreg, alusrca, imm_zext, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_q[$];
    string       tag_q[$];

    mips_main_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .iord       (iord),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .imm_zext   (imm_zext),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // {pcwrite,branch,branch_ne,irwrite,memwrite,iord,regwrite,regdst,memtoreg,
    //  alusrca,alusrcb,imm_zext,pcsrc,aluop,illegal_op}
    function automatic logic [18:0] mk(input logic pcw, br, bne, irw, mw, io, rw, rd, m2r,
                                       asa, input logic [1:0] asb, input logic iz,
                                       input logic [1:0] ps, input logic [2:0] ao,
                                       input logic ill);
        return {pcw, br, bne, irw, mw, io, rw, rd, m2r, asa, asb, iz, ps, ao, ill};
    endfunction

    function automatic logic [18:0] e_fetch(input logic mr);
        return mk(mr, 0, 0, mr, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [18:0] e_decode(input logic ill);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 3'b000, ill);
    endfunction
    function automatic logic [18:0] e_memadr();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [18:0] e_memrd();
        return mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [18:0] e_memwb();
        return mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [18:0] e_memwr();
        return mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [18:0] e_rtype();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 3'b010, 0);
    endfunction
    function automatic logic [18:0] e_aluwb();
        return mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [18:0] e_immex(input logic [2:0] ao, input logic iz);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, iz, 2'b00, ao, 0);
    endfunction
    function automatic logic [18:0] e_immwb();
        return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [18:0] e_branch(input logic beq, input logic bne);
        return mk(0, beq, bne, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 3'b001, 0);
    endfunction
    function automatic logic [18:0] e_jump();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 3'b000, 0);
    endfunction

    function automatic logic [18:0] observed();
        return {pcwrite, branch, branch_ne, irwrite, memwrite, iord, regwrite, regdst,
                memtoreg, alusrca, alusrcb, imm_zext, pcsrc, aluop, illegal_op};
    endfunction

    task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    // One clock of stimulus; its expected outputs go onto the scoreboard.
    task automatic cyc(input string tag, input logic rst, input logic [5:0] o,
                       input logic mr, input logic [18:0] e);
        @(negedge clk);
        rst_n     = rst;
        op        = o;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) check_eq(tag_q.pop_front(), observed(), exp_q.pop_front());
        end
    end

    initial begin
        rst_n     = 1'b0;
        op        = 6'b100011;
        mem_ready = 1'b1;

        // Reset with mem_ready high: FETCH selects but no enables.
        cyc("reset0", 0, 6'b100011, 1, e_fetch(0));
        cyc("reset1", 0, 6'b100011, 1, e_fetch(0));

        // lw, 5 cycles
        cyc("lw_fetch",  1, 6'b100011, 1, e_fetch(1));
        cyc("lw_decode", 1, 6'b100011, 1, e_decode(0));
        cyc("lw_memadr", 1, 6'b100011, 1, e_memadr());
        cyc("lw_memrd",  1, 6'b100011, 1, e_memrd());
        cyc("lw_memwb",  1, 6'b100011, 1, e_memwb());

        // R-type, 4 cycles
        cyc("r_fetch",  1, 6'b000000, 1, e_fetch(1));
        cyc("r_decode", 1, 6'b000000, 1, e_decode(0));
        cyc("r_ex",     1, 6'b000000, 1, e_rtype());
        cyc("r_wb",     1, 6'b000000, 1, e_aluwb());

        // ori and slti
        cyc("ori_fetch",  1, 6'b001101, 1, e_fetch(1));
        cyc("ori_decode", 1, 6'b001101, 1, e_decode(0));
        cyc("ori_ex",     1, 6'b001101, 1, e_immex(3'b100, 1));
        cyc("ori_wb",     1, 6'b001101, 1, e_immwb());
        cyc("slti_fetch",  1, 6'b001010, 1, e_fetch(1));
        cyc("slti_decode", 1, 6'b001010, 1, e_decode(0));
        cyc("slti_ex",     1, 6'b001010, 1, e_immex(3'b101, 0));
        cyc("slti_wb",     1, 6'b001010, 1, e_immwb());
        cyc("andi_fetch",  1, 6'b001100, 1, e_fetch(1));
        cyc("andi_decode", 1, 6'b001100, 1, e_decode(0));
        cyc("andi_ex",     1, 6'b001100, 1, e_immex(3'b011, 1));
        cyc("andi_wb",     1, 6'b001100, 1, e_immwb());

        // bne, beq, j: 3 cycles each
        cyc("bne_fetch",  1, 6'b000101, 1, e_fetch(1));
        cyc("bne_decode", 1, 6'b000101, 1, e_decode(0));
        cyc("bne_br",     1, 6'b000101, 1, e_branch(0, 1));
        cyc("beq_fetch",  1, 6'b000100, 1, e_fetch(1));
        cyc("beq_decode", 1, 6'b000100, 1, e_decode(0));
        cyc("beq_br",     1, 6'b000100, 1, e_branch(1, 0));
        cyc("j_fetch",  1, 6'b000010, 1, e_fetch(1));
        cyc("j_decode", 1, 6'b000010, 1, e_decode(0));
        cyc("j_jump",   1, 6'b000010, 1, e_jump());

        // sw with fetch stall and 3-cycle MEMWR stall
        cyc("sw_fetch_stall", 1, 6'b101011, 0, e_fetch(0));
        cyc("sw_fetch",  1, 6'b101011, 1, e_fetch(1));
        cyc("sw_decode", 1, 6'b101011, 1, e_decode(0));
        cyc("sw_memadr", 1, 6'b101011, 1, e_memadr());
        for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", 1, 6'b101011, 0, e_memwr());
        cyc("sw_memwr_done", 1, 6'b101011, 1, e_memwr());

        // illegal opcode: 2 cycles
        cyc("ill_fetch",  1, 6'b111111, 1, e_fetch(1));
        cyc("ill_decode", 1, 6'b111111, 1, e_decode(1));
        cyc("ill_back",   1, 6'b111111, 0, e_fetch(0));

        // lw aborted by reset during a stalled MEMRD
        cyc("ab_fetch",  1, 6'b100011, 1, e_fetch(1));
        cyc("ab_decode", 1, 6'b100011, 1, e_decode(0));
        cyc("ab_memadr", 1, 6'b100011, 1, e_memadr());
        cyc("ab_memrd",  1, 6'b100011, 0, e_memrd());
        #4;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check_eq("ab_async_rst", observed(), e_fetch(0));
        cyc("ab_rst_hold", 0, 6'b100011, 1, e_fetch(0));
        cyc("ab_release",  1, 6'b000010, 1, e_fetch(1));
        cyc("ab_decode2",  1, 6'b000010, 1, e_decode(0));
        cyc("ab_jump",     1, 6'b000010, 1, e_jump());

        @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
